// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, start, 8 data bits LSB first, odd parity, stop, ACK check.
// Optional macro PS2_TX_FILTER_EN adds an 8-sample agreement filter on the synced PS/2 clock.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
    localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StStart,
        StSend,
        StAck,
        StWaitIdle
    } state_e;

    state_e          state_q, state_d;
    logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [9:0]      frame_q, frame_d;
    logic            data_oe_q, data_oe_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    logic [1:0] clk_sync_q, data_sync_q;
    logic       clk_synced, data_synced, clk_clean, clk_prev_q;
    logic       edge_active, fall;

    // Idle bus level is high, so synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clock_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
        end
    end

    assign clk_synced  = clk_sync_q[1];
    assign data_synced = data_sync_q[1];

`ifdef PS2_TX_FILTER_EN
    logic [2:0] filt_cnt_q;
    logic       clk_filt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt_cnt_q <= 3'd0;
            clk_filt_q <= 1'b1;
        end else if (clk_synced == clk_filt_q) begin
            filt_cnt_q <= 3'd0;
        end else if (filt_cnt_q == 3'd7) begin
            filt_cnt_q <= 3'd0;
            clk_filt_q <= clk_synced;
        end else begin
            filt_cnt_q <= filt_cnt_q + 3'd1;
        end
    end

    assign clk_clean = clk_filt_q;
`else
    assign clk_clean = clk_synced;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= clk_clean;
        end
    end

    // Edges only matter once the device owns the clock line.
    assign edge_active = (state_q == StSend) || (state_q == StAck);
    assign fall        = edge_active && clk_prev_q && !clk_clean;

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    frame_d   = {1'b1, ~^tx_data, tx_data};
                    inh_cnt_d = '0;
                    bit_cnt_d = 4'd0;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                if (inh_cnt_q == InhLast) begin
                    data_oe_d = 1'b1;
                    state_d   = StStart;
                end else begin
                    inh_cnt_d = inh_cnt_q + InhW'(1);
                end
            end
            StStart: begin
                to_cnt_d = '0;
                state_d  = StSend;
            end
            StSend, StAck, StWaitIdle: begin
                if (to_cnt_q == ToLast) begin
                    // Timeout takes priority over any edge seen this cycle.
                    data_oe_d = 1'b0;
                    error_d   = 1'b1;
                    state_d   = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + ToW'(1);
                    if (state_q == StSend) begin
                        if (fall) begin
                            data_oe_d = ~frame_q[bit_cnt_q];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd9) begin
                                state_d = StAck;
                            end
                        end
                    end else if (state_q == StAck) begin
                        if (fall) begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            if (!data_synced) begin
                                state_d = StWaitIdle;
                            end else begin
                                error_d = 1'b1;
                                state_d = StIdle;
                            end
                        end
                    end else begin
                        if (clk_synced && data_synced) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: begin
                data_oe_d = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bit_cnt_q <= 4'd0;
            frame_q   <= 10'd0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign tx_ready     = (state_q == StIdle);
    assign tx_busy      = (state_q != StIdle);
    assign tx_done      = done_q;
    assign tx_error     = error_q;
    assign ps2_clock_oe = (state_q == StInhibit) || (state_q == StStart);
    assign ps2_data_oe  = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural keyboard that clocks frames,
// records line levels at each rising edge and optionally ACKs.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TO  = 1500;
    localparam int H   = 25;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, tx_done, tx_error;
    logic       ps2_clock_oe, ps2_data_oe;
    logic       ps2_clock_in, ps2_data_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         dev_mode = 0;   // 0 = ACK, 1 = no ACK, 2 = never clocks
    logic       dev_abort = 1'b0;
    int         dev_bitcnt = 0;
    logic [9:0] dev_q[$];

    assign ps2_clock_in = ~(ps2_clock_oe | dev_clk_low);
    assign ps2_data_in  = ~(ps2_data_oe | dev_data_low);

    always #5 clock = ~clock;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .ps2_clock_in(ps2_clock_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clock_oe(ps2_clock_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always @(negedge clock) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_error === 1'b1) err_cnt++;
    end

    // Expected line levels: data LSB first, odd parity, stop.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        int         ones;
        logic [9:0] f;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = b[i];
            if (b[i]) ones++;
        end
        f[8] = (ones % 2 == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    // Keyboard model: answers a request-to-send (clock released, data held low).
    initial begin : device
        logic [9:0] cap;
        forever begin
            @(negedge clock);
            if (ps2_clock_oe === 1'b0 && ps2_data_oe === 1'b1 && dev_mode != 2 && !dev_abort) begin
                cap = 10'd0;
                repeat (H) @(negedge clock);
                for (int i = 0; i < 11 && !dev_abort; i++) begin
                    if (i == 10 && dev_mode == 0) dev_data_low = 1'b1;
                    dev_clk_low = 1'b1;
                    repeat (H) @(negedge clock);
                    dev_clk_low = 1'b0;
                    if (i < 10) cap[i] = ps2_data_in;
                    dev_bitcnt = i + 1;
                    repeat (H) @(negedge clock);
                end
                dev_data_low = 1'b0;
                dev_clk_low  = 1'b0;
                if (!dev_abort) dev_q.push_back(cap);
            end
        end
    end

    task automatic wait_frame(input string name, output logic [9:0] got, output logic ok);
        int n;
        n = 0;
        while (dev_q.size() == 0 && n < 500) begin
            @(negedge clock);
            n++;
        end
        ok = (dev_q.size() != 0);
        got = 10'd0;
        if (ok) got = dev_q.pop_front();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s frame: got no frame, expected one", name);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        checks++;
        if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || ps2_clock_oe !== 1'b0 || ps2_data_oe !== 1'b0
            || tx_done !== 1'b0 || tx_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: ready=%b busy=%b coe=%b doe=%b done=%b err=%b, expected 1 0 0 0 0 0",
                     tx_ready, tx_busy, ps2_clock_oe, ps2_data_oe, tx_done, tx_error);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || ps2_clock_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b coe=%b doe=%b, expected 1 0 0 0",
                     tx_ready, tx_busy, ps2_clock_oe, ps2_data_oe);
        end
    endtask

    task automatic do_send(input logic [7:0] b, input int mode, input string name);
        int         d0, e0, n, m;
        logic       d_last, d_prev, ok;
        logic [9:0] got, exp;
        dev_mode = mode;
        d0 = done_cnt;
        e0 = err_cnt;
        n = 0;
        while (tx_ready !== 1'b1 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        checks++;
        if (tx_ready !== 1'b0 || tx_busy !== 1'b1 || ps2_clock_oe !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: ready=%b busy=%b coe=%b, expected 0 1 1",
                     name, tx_ready, tx_busy, ps2_clock_oe);
        end
        n = 0;
        d_last = 1'b0;
        d_prev = 1'b0;
        while (ps2_clock_oe === 1'b1 && n < INH + 50) begin
            d_prev = d_last;
            d_last = ps2_data_oe;
            n++;
            @(negedge clock);
        end
        checks++;
        if (n != INH + 1) begin
            errors++;
            $display("FAIL %s inhibit_len: got %0d cycles, expected %0d", name, n, INH + 1);
        end
        checks++;
        if (d_last !== 1'b1 || d_prev !== 1'b0) begin
            errors++;
            $display("FAIL %s start_bit: data_oe before clock release got %b%b, expected 01",
                     name, d_prev, d_last);
        end
        m = 0;
        while (tx_done !== 1'b1 && tx_error !== 1'b1 && m < TO + 100) begin
            @(negedge clock);
            m++;
        end
        checks++;
        if (m >= TO + 100) begin
            errors++;
            $display("FAIL %s completion: got no done/error pulse within %0d cycles", name, TO + 100);
        end else begin
            checks++;
            if (tx_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s ready_at_pulse: got %b, expected 1", name, tx_ready);
            end
        end
        if (mode == 2) begin
            checks++;
            if (m != TO) begin
                errors++;
                $display("FAIL %s timeout_latency: got %0d cycles, expected %0d", name, m, TO);
            end
        end
        repeat (3) @(negedge clock);
        checks++;
        if (ps2_clock_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: coe=%b doe=%b ready=%b, expected 0 0 1",
                     name, ps2_clock_oe, ps2_data_oe, tx_ready);
        end
        checks++;
        if (done_cnt - d0 != (mode == 0 ? 1 : 0) || err_cnt - e0 != (mode == 0 ? 0 : 1)) begin
            errors++;
            $display("FAIL %s pulses: done=%0d error=%0d, expected %0d %0d", name,
                     done_cnt - d0, err_cnt - e0, (mode == 0 ? 1 : 0), (mode == 0 ? 0 : 1));
        end
        if (mode != 2) begin
            wait_frame(name, got, ok);
            if (ok) begin
                exp = model_frame(b);
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL %s bits: got %b, expected %b (stop,parity,data msb..lsb)",
                             name, got, exp);
                end
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 4; i++) begin
            do_send(8'($urandom_range(0, 255)), 0, "random");
        end
    endtask

    task automatic test_reset_mid_frame;
        int n, d0, e0;
        dev_mode = 0;
        d0 = done_cnt;
        e0 = err_cnt;
        n = 0;
        while (tx_ready !== 1'b1 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        dev_bitcnt = 0;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        n = 0;
        while (dev_bitcnt < 4 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 3000 || ps2_clock_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid reach_bit4: got bitcnt=%0d coe=%b, expected 4 0",
                     dev_bitcnt, ps2_clock_oe);
        end
        #2;
        dev_abort = 1'b1;
        reset_n   = 1'b0;
        #1;
        checks++;
        if (ps2_clock_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid async: coe=%b doe=%b ready=%b busy=%b, expected 0 0 1 0",
                     ps2_clock_oe, ps2_data_oe, tx_ready, tx_busy);
        end
        repeat (4) @(negedge clock);
        reset_n = 1'b1;
        repeat (4 * H + 10) @(negedge clock);
        dev_abort = 1'b0;
        dev_q.delete();
        checks++;
        if (tx_ready !== 1'b1 || ps2_clock_oe !== 1'b0 || ps2_data_oe !== 1'b0
            || done_cnt != d0 || err_cnt != e0) begin
            errors++;
            $display("FAIL reset_mid idle: ready=%b coe=%b doe=%b done=%0d err=%0d, expected 1 0 0 0 0",
                     tx_ready, ps2_clock_oe, ps2_data_oe, done_cnt - d0, err_cnt - e0);
        end
        do_send(8'hFF, 0, "post_reset_ff");
    endtask

    task automatic test_back_to_back;
        int         n, d0;
        logic       ok;
        logic [9:0] got;
        dev_mode = 0;
        d0 = done_cnt;
        n = 0;
        while (tx_ready !== 1'b1 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_data = 8'h34;
        n = 0;
        while (tx_done !== 1'b1 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 3000 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b first_done: got ready=%b after %0d cycles, expected 1", tx_ready, n);
        end
        @(negedge clock);
        tx_valid = 1'b0;
        checks++;
        if (tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b second_accept: busy=%b, expected 1", tx_busy);
        end
        n = 0;
        while (done_cnt - d0 < 2 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        checks++;
        if (done_cnt - d0 != 2) begin
            errors++;
            $display("FAIL b2b done_count: got %0d, expected 2", done_cnt - d0);
        end
        wait_frame("b2b_first", got, ok);
        if (ok) begin
            checks++;
            if (got !== model_frame(8'h12)) begin
                errors++;
                $display("FAIL b2b_first bits: got %b, expected %b", got, model_frame(8'h12));
            end
        end
        wait_frame("b2b_second", got, ok);
        if (ok) begin
            checks++;
            if (got !== model_frame(8'h34)) begin
                errors++;
                $display("FAIL b2b_second bits: got %b, expected %b", got, model_frame(8'h34));
            end
        end
        repeat (4 * H) @(negedge clock);
        checks++;
        if (dev_q.size() != 0 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b extra: frames=%0d busy=%b, expected 0 0", dev_q.size(), tx_busy);
        end
    endtask

    initial begin
        test_reset();
        do_send(8'hED, 0, "send_ed");
        do_send(8'h00, 0, "send_00");
        do_send(8'h01, 0, "send_01");
        test_random();
        do_send(8'h5A, 1, "no_ack");
        do_send(8'hF4, 2, "timeout");
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
